// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed load/store requests into word-addressed
// memory accesses, with lane extraction and sign/zero extension on loads and
// read-modify-write merging on sub-word stores.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_misaligned,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_writeEnable,
    output logic [DATA_WIDTH-1:0] mem_dataIn,
    input  logic [DATA_WIDTH-1:0] mem_dataOut
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MERGE = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [1:0]              size_q, size_d;
    logic                    write_q, write_d;
    logic                    unsigned_q, unsigned_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   merge_q, merge_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    misaligned_q, misaligned_d;

    logic                    req_misaligned;
    logic [7:0]              rd_byte [4];
    logic [DATA_WIDTH-1:0]   merge_word;
    logic [7:0]              load_byte;
    logic [15:0]             load_half;
    logic [DATA_WIDTH-1:0]   load_ext;

    // Alignment check on the incoming (not yet latched) request
    assign req_misaligned = (req_size == 2'b11)
                          || ((req_size == SZ_HALF) && req_addr[0])
                          || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

    // Per-byte-lane view of the read word and the sub-word store merge
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam int HB = gi % 2;
            logic lane_sel;
            assign rd_byte[gi] = mem_dataOut[8*gi+7:8*gi];
            // Byte stores hit one lane; halfword stores hit the pair picked by addr[1]
            assign lane_sel = (size_q == SZ_BYTE) ? (addr_q[1:0] == 2'(gi))
                                                  : (addr_q[1] == ((gi / 2) == 1));
            assign merge_word[8*gi+7:8*gi] = !lane_sel           ? rd_byte[gi]
                                           : (size_q == SZ_BYTE) ? wdata_q[7:0]
                                           :                       wdata_q[8*HB+7:8*HB];
        end
    endgenerate

    // Lane selection and extension of load data
    always_comb begin
        load_byte = rd_byte[addr_q[1:0]];
        load_half = addr_q[1] ? mem_dataOut[31:16] : mem_dataOut[15:0];
        case (size_q)
            SZ_BYTE: load_ext = unsigned_q ? {{(DATA_WIDTH-8){1'b0}}, load_byte}
                                           : {{(DATA_WIDTH-8){load_byte[7]}}, load_byte};
            SZ_HALF: load_ext = unsigned_q ? {{(DATA_WIDTH-16){1'b0}}, load_half}
                                           : {{(DATA_WIDTH-16){load_half[15]}}, load_half};
            default: load_ext = mem_dataOut;
        endcase
    end

    // Next-state and latched-field logic
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        write_d      = write_q;
        unsigned_d   = unsigned_q;
        wdata_d      = wdata_q;
        merge_d      = merge_q;
        rdata_d      = rdata_q;
        misaligned_d = misaligned_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d     = req_addr;
                    size_d     = req_size;
                    write_d    = req_write;
                    unsigned_d = req_unsigned;
                    wdata_d    = req_wdata;
                    if (req_misaligned) begin
                        rdata_d      = '0;
                        misaligned_d = 1'b1;
                        state_d      = RESP;
                    end else if (!req_write) begin
                        state_d = LOAD;
                    end else if (req_size == SZ_WORD) begin
                        state_d = WRITE;
                    end else begin
                        state_d = MERGE;
                    end
                end
            end
            LOAD: begin
                rdata_d      = load_ext;
                misaligned_d = 1'b0;
                state_d      = RESP;
            end
            MERGE: begin
                merge_d = merge_word;
                state_d = WRITE;
            end
            WRITE: begin
                rdata_d      = '0;
                misaligned_d = 1'b0;
                state_d      = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and field registers; reset wins in every state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            size_q       <= '0;
            write_q      <= 1'b0;
            unsigned_q   <= 1'b0;
            wdata_q      <= '0;
            merge_q      <= '0;
            rdata_q      <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            write_q      <= write_d;
            unsigned_q   <= unsigned_d;
            wdata_q      <= wdata_d;
            merge_q      <= merge_d;
            rdata_q      <= rdata_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Outputs; the write strobe and response pulse are masked by reset so an
    // aborted request neither writes memory nor reports completion
    assign req_ready       = (state_q == IDLE);
    assign resp_valid      = (state_q == RESP) && !reset;
    assign resp_rdata      = rdata_q;
    assign resp_misaligned = misaligned_q;
    assign mem_address     = {2'b00, addr_q[ADDR_WIDTH-1:2]};
    assign mem_writeEnable = (state_q == WRITE) && write_q && !reset;
    assign mem_dataIn      = (size_q == SZ_WORD) ? wdata_q : merge_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a small word memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic [31:0] mem_address;
    logic        mem_writeEnable;
    logic [31:0] mem_dataIn;
    logic [31:0] mem_dataOut;

    logic [31:0] mem [16];
    int tests = 0;
    int failed = 0;
    int we_events = 0;
    int resp_events = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_misaligned(resp_misaligned), .mem_address(mem_address),
        .mem_writeEnable(mem_writeEnable), .mem_dataIn(mem_dataIn),
        .mem_dataOut(mem_dataOut)
    );

    assign mem_dataOut = mem[mem_address[3:0]];

    always @(posedge clk) begin
        if (mem_writeEnable) begin
            mem[mem_address[3:0]] <= mem_dataIn;
            we_events <= we_events + 1;
        end
        if (resp_valid) resp_events <= resp_events + 1;
    end

    // One request: accept, then watch until resp_valid (latency counted from acceptance cycle)
    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic mis,
                          output int we_n, output int we_at, output logic [31:0] addr_seen);
        @(negedge clk);
        tests++;
        if (req_ready !== 1'b1) begin
            failed++;
            $display("FAIL req_ready_idle: got %b expected 1", req_ready);
        end
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0; we_n = 0; we_at = 0; rd = '0; mis = 1'b0;
        addr_seen = mem_address;
        for (int i = 1; i <= 8; i++) begin
            if (mem_writeEnable) begin we_n++; we_at = i; end
            if (resp_valid) begin
                lat = i; rd = resp_rdata; mis = resp_misaligned;
                break;
            end
            @(negedge clk);
        end
        $display("[TB] req w=%0d sz=%0d u=%0d addr=%h wdata=%h -> lat=%0d rdata=%h mis=%0d we=%0d",
                 w, sz, u, a, wd, lat, rd, mis, we_n);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_writeEnable !== 1'b0 ||
            resp_rdata !== 32'h0 || resp_misaligned !== 1'b0 || mem_address !== 32'h0) begin
            failed++;
            $display("FAIL reset_state: ready=%b rv=%b we=%b rdata=%h mis=%b addr=%h expected 1 0 0 0 0 0",
                     req_ready, resp_valid, mem_writeEnable, resp_rdata, resp_misaligned, mem_address);
        end
    endtask

    task automatic test_word();
        int lat, we_n, we_at; logic [31:0] rd, as; logic mis;
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, lat, rd, mis, we_n, we_at, as);
        tests++;
        if (lat != 2 || we_n != 1 || we_at != 1 || as !== 32'h4 || mis !== 1'b0 || rd !== 32'h0) begin
            failed++;
            $display("FAIL word_store: lat=%0d we_n=%0d we_at=%0d addr=%h mis=%b rd=%h expected 2 1 1 4 0 0",
                     lat, we_n, we_at, as, mis, rd);
        end
        tests++;
        if (mem[4] !== 32'h11223344) begin
            failed++; $display("FAIL word_store_mem: got %h expected 11223344", mem[4]);
        end
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, mis, we_n, we_at, as);
        tests++;
        if (lat != 2 || rd !== 32'h11223344 || mis !== 1'b0 || we_n != 0) begin
            failed++;
            $display("FAIL word_load: lat=%0d rd=%h mis=%b we=%0d expected 2 11223344 0 0", lat, rd, mis, we_n);
        end
        // Top byte address: word index is addr >> 2 with zero fill
        do_req(1'b0, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h0, lat, rd, mis, we_n, we_at, as);
        tests++;
        if (as !== 32'h3FFFFFFF || rd !== 32'h0BADF00D || lat != 2) begin
            failed++;
            $display("FAIL word_load_high: addr=%h rd=%h lat=%0d expected 3fffffff 0badf00d 2", as, rd, lat);
        end
    endtask

    task automatic test_byte();
        int lat, we_n, we_at; logic [31:0] rd, as; logic mis;
        do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000AA, lat, rd, mis, we_n, we_at, as);
        tests++;
        if (lat != 3 || we_n != 1 || we_at != 2 || mem[4] !== 32'hAA223344) begin
            failed++;
            $display("FAIL byte_store: lat=%0d we_n=%0d we_at=%0d mem4=%h expected 3 1 2 aa223344",
                     lat, we_n, we_at, mem[4]);
        end
        do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, rd, mis, we_n, we_at, as);
        tests++;
        if (rd !== 32'hFFFFFFAA || lat != 2) begin
            failed++; $display("FAIL byte_load_signed: rd=%h lat=%0d expected ffffffaa 2", rd, lat);
        end
        do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, rd, mis, we_n, we_at, as);
        tests++;
        if (rd !== 32'h000000AA) begin
            failed++; $display("FAIL byte_load_unsigned: rd=%h expected 000000aa", rd);
        end
    endtask

    task automatic test_half();
        int lat, we_n, we_at; logic [31:0] rd, as; logic mis;
        do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000BEEF, lat, rd, mis, we_n, we_at, as);
        tests++;
        if (lat != 3 || we_n != 1 || mem[4] !== 32'hBEEF3344) begin
            failed++;
            $display("FAIL half_store: lat=%0d we_n=%0d mem4=%h expected 3 1 beef3344", lat, we_n, mem[4]);
        end
        do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat, rd, mis, we_n, we_at, as);
        tests++;
        if (rd !== 32'hFFFFBEEF) begin
            failed++; $display("FAIL half_load_signed: rd=%h expected ffffbeef", rd);
        end
        do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, lat, rd, mis, we_n, we_at, as);
        tests++;
        if (rd !== 32'h00003344) begin
            failed++; $display("FAIL half_load_unsigned: rd=%h expected 00003344", rd);
        end
        do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, lat, rd, mis, we_n, we_at, as);
        tests++;
        if (rd !== 32'h00000033) begin
            failed++; $display("FAIL byte1_load: rd=%h expected 00000033", rd);
        end
    endtask

    task automatic test_misaligned();
        int lat, we_n, we_at, w0; logic [31:0] rd, as; logic mis;
        logic        mw [3] = '{1'b0, 1'b1, 1'b1};
        logic [1:0]  ms [3] = '{2'b01, 2'b10, 2'b11};
        logic [31:0] ma [3] = '{32'h11, 32'h12, 32'h10};
        for (int k = 0; k < 3; k++) begin
            w0 = we_events;
            do_req(mw[k], ms[k], 1'b0, ma[k], 32'hDEADBEEF, lat, rd, mis, we_n, we_at, as);
            @(negedge clk);
            tests++;
            if (lat != 1 || mis !== 1'b1 || rd !== 32'h0 || we_n != 0 || we_events != w0 ||
                mem[4] !== 32'hBEEF3344) begin
                failed++;
                $display("FAIL misaligned_%0d: lat=%0d mis=%b rd=%h we=%0d mem4=%h expected 1 1 0 0 beef3344",
                         k, lat, mis, rd, we_n, mem[4]);
            end
        end
    endtask

    task automatic test_reset_abort();
        int w0, r0;
        // Reset during MERGE of a byte store
        w0 = we_events; r0 = resp_events;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h14; req_wdata = 32'h000000CC;
        @(negedge clk);
        req_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (req_ready !== 1'b1) begin
            failed++; $display("FAIL abort_merge_ready: got %b expected 1", req_ready);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (mem[5] !== 32'h55667788 || we_events != w0 || resp_events != r0) begin
            failed++;
            $display("FAIL abort_merge: mem5=%h writes=%0d resps=%0d expected 55667788 0 0",
                     mem[5], we_events - w0, resp_events - r0);
        end
        $display("[TB] reset during MERGE: mem5=%h", mem[5]);
        // Reset during WRITE of a word store
        w0 = we_events; r0 = resp_events;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h14;
        req_wdata = 32'h12345678;
        @(negedge clk);
        req_valid = 1'b0;
        tests++;
        if (mem_writeEnable !== 1'b1) begin
            failed++; $display("FAIL write_strobe_before_reset: got %b expected 1", mem_writeEnable);
        end
        reset = 1'b1;
        #1;
        tests++;
        if (mem_writeEnable !== 1'b0) begin
            failed++; $display("FAIL write_strobe_in_reset: got %b expected 0", mem_writeEnable);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (mem[5] !== 32'h55667788 || we_events != w0 || resp_events != r0 || req_ready !== 1'b1) begin
            failed++;
            $display("FAIL abort_write: mem5=%h writes=%0d resps=%0d ready=%b expected 55667788 0 0 1",
                     mem[5], we_events - w0, resp_events - r0, req_ready);
        end
        $display("[TB] reset during WRITE: mem5=%h", mem[5]);
    endtask

    task automatic test_back_to_back();
        logic [1:0]  bs [3] = '{2'b10, 2'b00, 2'b01};
        logic        bu [3] = '{1'b0, 1'b0, 1'b1};
        logic [31:0] ba [3] = '{32'h10, 32'h13, 32'h12};
        logic [31:0] be [3] = '{32'hBEEF3344, 32'hFFFFFFBE, 32'h0000BEEF};
        int acc_cyc [3];
        int acc = 0;
        int got = 0;
        @(negedge clk);
        for (int cyc = 0; cyc < 30 && got < 3; cyc++) begin
            if (resp_valid) begin
                tests++;
                if (resp_rdata !== be[got] || resp_misaligned !== 1'b0) begin
                    failed++;
                    $display("FAIL b2b_data_%0d: rd=%h mis=%b expected %h 0",
                             got, resp_rdata, resp_misaligned, be[got]);
                end
                $display("[TB] b2b resp %0d rdata=%h", got, resp_rdata);
                got++;
            end
            if (req_ready) begin
                if (acc < 3) begin
                    req_valid = 1'b1; req_write = 1'b0; req_size = bs[acc];
                    req_unsigned = bu[acc]; req_addr = ba[acc];
                    acc_cyc[acc] = cyc;
                    acc++;
                end else begin
                    req_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        tests++;
        if (got != 3 || acc != 3 || acc_cyc[1] - acc_cyc[0] != 3 || acc_cyc[2] - acc_cyc[1] != 3) begin
            failed++;
            $display("FAIL b2b_spacing: resps=%0d accepts=%0d gaps=%0d,%0d expected 3 3 3,3",
                     got, acc, acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[5]  = 32'h55667788;
        mem[15] = 32'h0BADF00D;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misaligned();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
